// File: rtl/mix_pkg.sv
// mix_pkg: shared MIX word/field-spec types and field-extractor FSM states.
package mix_pkg;
  localparam int BYTE_W = 6;
  localparam int NBYTES = 5;
  localparam int SIGN_BIT = 30;
  localparam int MAG_W = NBYTES * BYTE_W;
  localparam int WORD_W = MAG_W + 1;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic [2:0] l;
    logic [2:0] r;
  } fspec_t;
  typedef enum logic [1:0] {IDLE, SHIFT, MASK} state_t;
endpackage

// File: rtl/field_sel_if.sv
// field_sel_if: start/stop request bus between a requester and the field extractor.
interface field_sel_if;
  import mix_pkg::*;
  logic   start;
  word_t  in;
  fspec_t f;
  word_t  out;
  logic   stop;
  logic   busy;
  logic   err;
  modport master(output start, in, f, input out, stop, busy, err);
  modport slave(input start, in, f, output out, stop, busy, err);
endinterface

// File: rtl/field_mask.sv
// field_mask: magnitude byte mask and sign-keep flag for a field spec (L:R).
module field_mask
  import mix_pkg::*;
(
  input  logic [2:0]       l,
  input  logic [2:0]       r,
  output logic [MAG_W-1:0] mask,
  output logic             sign_keep
);
  logic [2:0] lo;
  logic [2:0] n;
  always_comb begin
    lo = (l == 3'd0) ? 3'd1 : l;
    n = (r == 3'd0 || lo > r) ? 3'd0 : r - lo + 3'd1;
    mask = ~({MAG_W{1'b1}} << (n * BYTE_W));
    sign_keep = l == 3'd0;
  end
endmodule

// File: rtl/field_sel.sv
// field_sel: MIX (L:R) field extractor; define FIELD_SEL_FAST_EN for a single-cycle barrel-shift build.
module field_sel
  import mix_pkg::*;
(
  input logic        clk,
  input logic        rst,
  field_sel_if.slave bus
);
  state_t           state, state_n;
  logic [2:0]       l_q, r_q, cnt, load_cnt;
  logic             sign_q, err_q, keep, bad;
  logic [MAG_W-1:0] mag_q, mask, load_mag;
  assign bad = bus.f.r > 3'd5 || bus.f.l > bus.f.r;
`ifdef FIELD_SEL_FAST_EN
  assign load_mag = bus.in[MAG_W-1:0] >> (BYTE_W * (3'd5 - bus.f.r));
  assign load_cnt = 3'd0;
`else
  assign load_mag = bus.in[MAG_W-1:0];
  assign load_cnt = 3'd5 - bus.f.r;
`endif
  field_mask u_mask (.l(l_q), .r(r_q), .mask(mask), .sign_keep(keep));
  always_comb begin
    state_n = state == MASK  ? IDLE :
              state == SHIFT ? (cnt == 3'd1 ? MASK : SHIFT) :
              !bus.start     ? IDLE :
              (bad || load_cnt == 3'd0) ? MASK : SHIFT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q <= '0;
      r_q <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      err_q <= 1'b0;
      mag_q <= '0;
      bus.out <= '0;
      bus.stop <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.stop <= state == MASK;
      // busy spans the cycles strictly between acceptance and completion
      bus.busy <= state != IDLE && state_n != IDLE;
      if (state == IDLE && bus.start) begin
        l_q <= bus.f.l;
        r_q <= bus.f.r;
        sign_q <= bus.in[SIGN_BIT];
        mag_q <= load_mag;
        cnt <= bad ? 3'd0 : load_cnt;
        err_q <= bad;
        bus.err <= 1'b0;
      end else if (state == SHIFT) begin
        mag_q <= mag_q >> BYTE_W;
        cnt <= cnt - 3'd1;
      end
      if (state == MASK) begin
        bus.out <= err_q ? '0 : {keep & sign_q, mag_q & mask};
        bus.err <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_field_sel.sv
// tb_field_sel: directed plus random checks of field_sel against an arithmetic field model.
module tb_field_sel;
  import mix_pkg::*;
`ifdef FIELD_SEL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  field_sel_if bus ();
  field_sel dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {err, out}: bytes max(L,1)..R of the magnitude as a base-64 number, sign only when L=0
  function automatic logic [31:0] model(logic [30:0] w, logic [5:0] f);
    int l = int'(f[5:3]);
    int r = int'(f[2:0]);
    int n;
    longint unsigned mag = longint'(w[29:0]);
    if (r > 5 || l > r) return 32'h8000_0000;
    n = (r == 0) ? 0 : r - ((l == 0) ? 1 : l) + 1;
    mag = (mag / (longint'(64) ** (5 - r))) % (longint'(64) ** n);
    return {1'b0, (l == 0) ? w[30] : 1'b0, 30'(mag)};
  endfunction

  task automatic run(string tag, logic [30:0] w, logic [5:0] f, int inj);
    logic [31:0] e = model(w, f);
    int exp_lat = (e[31] || FAST) ? 1 : 6 - int'(f[2:0]);
    int lat = 1;
    int busy_n = 0;
    logic [30:0] o;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = w;
    bus.f = f;
    @(posedge clk);
    #1;
    bus.in = 31'($urandom);
    bus.f = 6'($urandom);
    while (lat <= 20) begin
      @(posedge clk);
      #1;
      if (bus.stop) break;
      if (bus.busy) busy_n++;
      bus.start = (lat == inj);
      bus.f = 6'd5;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " out"}, 32'(bus.out), 32'(e[30:0]));
    chk({tag, " err"}, 32'(bus.err), 32'(e[31]));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    chk({tag, " busy at stop"}, 32'(bus.busy), 32'd0);
    o = bus.out;
    @(posedge clk);
    #1;
    chk({tag, " stop width"}, 32'(bus.stop), 32'd0);
    chk({tag, " out held"}, 32'(bus.out), 32'(o));
  endtask

  initial begin
    logic [30:0] w0 = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    int stop_seen = 0;
    bus.start = 1'b0;
    bus.in = '0;
    bus.f = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", 32'(bus.out), 32'd0);
    chk("reset stop", 32'(bus.stop), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("f5", w0, 6'd5, 0);
    run("f13", w0, 6'd13, 0);
    run("f27", w0, 6'd27, 0);
    run("f0 ignored start", w0, 6'd0, 2);
    run("f34", w0, 6'd34, 0);
    run("f45", w0, 6'd45, 0);
    run("f16", w0, 6'd16, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = w0;
    bus.f = 6'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort out", 32'(bus.out), 32'd0);
    chk("abort stop", 32'(bus.stop), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.stop) stop_seen++;
    end
    chk("abort no stop", 32'(stop_seen), 32'd0);
    run("f9 after abort", w0, 6'd9, 0);
    repeat (40) begin
      logic [5:0] f;
      logic [2:0] r;
      r = 3'($urandom_range(0, 5));
      f = ($urandom_range(0, 9) < 7) ? {3'($urandom_range(0, int'(r))), r} : 6'($urandom);
      run("random", 31'($urandom), f, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
